mem_bus_arbiter: RTL and testbench

- Two-requester arbiter that shares the single GBA memory bus (addr/data/width/read/write/ok) between port 0 (CPU core) and port 1 (DMA engine).
- Accepts at most one transaction at a time and registers the winning request onto the bus.
- Returns completion (ok, rdata, err) only to the granted requester.
- A watchdog aborts transactions that never receive mem_ok.

---
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus bundle: two requester ports, the memory side,
// and the arbiter status outputs.
interface mem_bus_arbiter_if;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [1:0]  p0_width;
  logic        p0_read;
  logic        p0_write;
  logic        p0_ok;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [1:0]  p1_width;
  logic        p1_read;
  logic        p1_write;
  logic        p1_ok;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ok;

  logic        grant;
  logic        busy;

  modport master (
    output p0_addr, p0_wdata, p0_width, p0_read, p0_write,
    input  p0_ok, p0_rdata, p0_err,
    output p1_addr, p1_wdata, p1_width, p1_read, p1_write,
    input  p1_ok, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_width, mem_read, mem_write,
    output mem_rdata, mem_ok,
    input  grant, busy
  );

  modport slave (
    input  p0_addr, p0_wdata, p0_width, p0_read, p0_write,
    output p0_ok, p0_rdata, p0_err,
    input  p1_addr, p1_wdata, p1_width, p1_read, p1_write,
    output p1_ok, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_width, mem_read, mem_write,
    input  mem_rdata, mem_ok,
    output grant, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared memory bus with a bus-wait watchdog.
// One transaction in flight; completion is routed only to the owner.
module mem_bus_arbiter #(
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned TIMEOUT = 1024,
  parameter int          CNT_W   = 11
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             req0;
  logic             req1;
  logic             win;
  logic             tmo;

  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_width;
  logic        w_read;
  logic        w_write;

  assign req0 = bus.p0_read | bus.p0_write;
  assign req1 = bus.p1_read | bus.p1_write;
  assign tmo  = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    win = 1'b0;
    unique case ({req1, req0})
      2'b11:   win = RR_MODE ? ~last_grant : 1'b0;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  // Write wins when a port raises both strobes.
  always_comb begin
    w_addr  = win ? bus.p1_addr  : bus.p0_addr;
    w_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    w_width = win ? bus.p1_width : bus.p0_width;
    w_write = win ? bus.p1_write : bus.p0_write;
    w_read  = (win ? bus.p1_read : bus.p0_read) & ~w_write;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 | req1) state_nxt = BUSY;
      BUSY:    if (bus.mem_ok | tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      bus.grant     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_width <= 2'd2;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.p0_ok     <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_ok     <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.p1_rdata  <= '0;
    end else begin
      state        <= state_nxt;
      bus.p0_ok    <= 1'b0;
      bus.p0_err   <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_ok    <= 1'b0;
      bus.p1_err   <= 1'b0;
      bus.p1_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            bus.mem_addr  <= w_addr;
            bus.mem_wdata <= w_wdata;
            bus.mem_width <= w_width;
            bus.mem_read  <= w_read;
            bus.mem_write <= w_write;
            bus.grant     <= win;
            last_grant    <= win;
            bus.busy      <= 1'b1;
            cnt           <= '0;
          end
        end
        BUSY: begin
          if (bus.mem_ok) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (bus.grant) begin
              bus.p1_ok    <= 1'b1;
              bus.p1_rdata <= bus.mem_write ? '0 : bus.mem_rdata;
            end else begin
              bus.p0_ok    <= 1'b1;
              bus.p0_rdata <= bus.mem_write ? '0 : bus.mem_rdata;
            end
          end else if (tmo) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (bus.grant) begin
              bus.p1_ok  <= 1'b1;
              bus.p1_err <= 1'b1;
            end else begin
              bus.p0_ok  <= 1'b1;
              bus.p0_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    bus.busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a
// transaction-level reference model (round-robin and fixed-priority).
module tb_mem_bus_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic [31:0] a[2];
  logic [31:0] d[2];
  logic [1:0]  w[2];
  logic        rd[2];
  logic        wr[2];
  logic        mem_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail = 0;
  int gseq[8];
  int gap_v;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_rr ();
  mem_bus_arbiter_if bus_fp ();

  mem_bus_arbiter #(.RR_MODE(1'b1), .TIMEOUT(TO), .CNT_W(4))
    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  mem_bus_arbiter #(.RR_MODE(1'b0), .TIMEOUT(TO), .CNT_W(4))
    dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  assign bus_rr.p0_addr   = a[0];
  assign bus_rr.p0_wdata  = d[0];
  assign bus_rr.p0_width  = w[0];
  assign bus_rr.p0_read   = rd[0];
  assign bus_rr.p0_write  = wr[0];
  assign bus_rr.p1_addr   = a[1];
  assign bus_rr.p1_wdata  = d[1];
  assign bus_rr.p1_width  = w[1];
  assign bus_rr.p1_read   = rd[1];
  assign bus_rr.p1_write  = wr[1];
  assign bus_rr.mem_rdata = mem_rdata;
  assign bus_rr.mem_ok    = mem_ok & ~sel;

  assign bus_fp.p0_addr   = a[0];
  assign bus_fp.p0_wdata  = d[0];
  assign bus_fp.p0_width  = w[0];
  assign bus_fp.p0_read   = rd[0];
  assign bus_fp.p0_write  = wr[0];
  assign bus_fp.p1_addr   = a[1];
  assign bus_fp.p1_wdata  = d[1];
  assign bus_fp.p1_width  = w[1];
  assign bus_fp.p1_read   = rd[1];
  assign bus_fp.p1_write  = wr[1];
  assign bus_fp.mem_rdata = mem_rdata;
  assign bus_fp.mem_ok    = mem_ok & sel;

  logic        o_busy, o_grant, o_mrd, o_mwr;
  logic [31:0] o_maddr, o_mwd;
  logic [1:0]  o_mwi;
  logic        o_ok[2];
  logic        o_err[2];
  logic [31:0] o_rd[2];

  assign o_busy   = sel ? bus_fp.busy      : bus_rr.busy;
  assign o_grant  = sel ? bus_fp.grant     : bus_rr.grant;
  assign o_mrd    = sel ? bus_fp.mem_read  : bus_rr.mem_read;
  assign o_mwr    = sel ? bus_fp.mem_write : bus_rr.mem_write;
  assign o_maddr  = sel ? bus_fp.mem_addr  : bus_rr.mem_addr;
  assign o_mwd    = sel ? bus_fp.mem_wdata : bus_rr.mem_wdata;
  assign o_mwi    = sel ? bus_fp.mem_width : bus_rr.mem_width;
  assign o_ok[0]  = sel ? bus_fp.p0_ok     : bus_rr.p0_ok;
  assign o_ok[1]  = sel ? bus_fp.p1_ok     : bus_rr.p1_ok;
  assign o_err[0] = sel ? bus_fp.p0_err    : bus_rr.p0_err;
  assign o_err[1] = sel ? bus_fp.p1_err    : bus_rr.p1_err;
  assign o_rd[0]  = sel ? bus_fp.p0_rdata  : bus_rr.p0_rdata;
  assign o_rd[1]  = sel ? bus_fp.p1_rdata  : bus_rr.p1_rdata;

  // Reference model: owner of the bus (-1 = free), bus-wait age,
  // and the single settle cycle after a completion.
  int          m_own;
  bit          m_done;
  int          m_age;
  bit          m_last;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_width;
  bit          e_rd, e_wr, e_grant, chk_bus;
  bit          e_ok[2];
  bit          e_err[2];
  logic [31:0] e_rdata[2];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    bit          s_rst, s_mok;
    logic [31:0] s_mrd;
    logic [31:0] sa[2];
    logic [31:0] sd[2];
    logic [1:0]  sw[2];
    bit          sr[2];
    bit          sx[2];
    bit          q[2];
    int          win;
    s_rst = rst;
    s_mok = mem_ok;
    s_mrd = mem_rdata;
    for (int i = 0; i < 2; i++) begin
      sa[i] = a[i];
      sd[i] = d[i];
      sw[i] = w[i];
      sr[i] = rd[i];
      sx[i] = wr[i];
      q[i]  = rd[i] | wr[i];
    end
    @(posedge clk);
    e_ok  = '{1'b0, 1'b0};
    e_err = '{1'b0, 1'b0};
    chk_bus = s_rst;
    if (s_rst) begin
      m_own = -1; m_done = 0; m_age = 0; m_last = 1;
      e_addr = '0; e_wdata = '0; e_width = 2'd2;
      e_rd = 0; e_wr = 0; e_grant = 0;
    end else if (m_done) begin
      m_done = 0;
      m_own  = -1;
    end else if (m_own >= 0) begin
      if (s_mok) begin
        e_ok[m_own]    = 1;
        e_rdata[m_own] = e_wr ? 32'h0 : s_mrd;
        e_rd = 0; e_wr = 0; m_done = 1;
      end else if (m_age == TO - 1) begin
        e_ok[m_own]    = 1;
        e_err[m_own]   = 1;
        e_rdata[m_own] = '0;
        e_rd = 0; e_wr = 0; m_done = 1;
      end else begin
        m_age++;
      end
    end else if (q[0] || q[1]) begin
      if (q[0] && q[1]) win = sel ? 0 : (m_last ? 0 : 1);
      else              win = q[1] ? 1 : 0;
      m_own = win; m_last = win[0]; e_grant = win[0];
      m_age = 0;
      e_addr = sa[win]; e_wdata = sd[win]; e_width = sw[win];
      e_wr = sx[win];
      e_rd = sr[win] & ~sx[win];
    end
    chk_bus = chk_bus | e_rd | e_wr;
    #1;
    chk("busy", o_busy, m_own >= 0);
    if (m_own >= 0 || s_rst) chk("grant", o_grant, e_grant);
    chk("mem_read", o_mrd, e_rd);
    chk("mem_write", o_mwr, e_wr);
    if (chk_bus) begin
      chk("mem_addr", o_maddr, e_addr);
      chk("mem_wdata", o_mwd, e_wdata);
      chk("mem_width", o_mwi, e_width);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("p%0d_ok", i), o_ok[i], e_ok[i]);
      chk($sformatf("p%0d_err", i), o_err[i], e_err[i]);
      if (e_ok[i])
        chk($sformatf("p%0d_rdata", i), o_rd[i], e_rdata[i]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    mem_ok = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic run_tx(int p, logic [31:0] ad, logic [31:0] wd,
                        logic [1:0] wi, bit r, bit x, int wt,
                        logic [31:0] rdv, output int hi,
                        output int oks, output logic [31:0] rdo,
                        output bit ero);
    a[p] = ad; d[p] = wd; w[p] = wi; rd[p] = r; wr[p] = x;
    hi = 0; oks = 0; rdo = 'x; ero = 0;
    for (int c = 0; c < 40 && oks == 0; c++) begin
      mem_ok = (o_mrd | o_mwr) && (hi == wt + 1);
      mem_rdata = rdv;
      tick();
      if (o_mrd | o_mwr) hi++;
      if (o_ok[p]) begin
        oks++;
        rdo = o_rd[p];
        ero = o_err[p];
        rd[p] = 0;
        wr[p] = 0;
      end
    end
    mem_ok = 0;
    tick();
  endtask

  task automatic both_held(int ng);
    int hi = 0;
    int c_ok = -1;
    int k = 0;
    bit prev = 0;
    gap_v = -1;
    for (int i = 0; i < 2; i++) begin
      a[i] = 32'h100 * (i + 1);
      d[i] = '0; w[i] = 2'd2; rd[i] = 1; wr[i] = 0;
    end
    for (int c = 0; c < 100 && k < ng; c++) begin
      mem_ok = o_mrd && (hi == 2);
      mem_rdata = 32'(c);
      tick();
      if (o_mrd) begin
        if (!prev) begin
          gseq[k] = int'(o_grant);
          if (k == 1) gap_v = c - c_ok;
          k++;
          hi = 0;
        end
        hi++;
      end
      prev = o_mrd;
      if (o_ok[0] && c_ok < 0) c_ok = c;
    end
    chk("held_grants", k, ng);
  endtask

  task automatic run_random(int n);
    bit pend[2];
    int age = 0;
    int lat = 0;
    bit prev = 0;
    pend = '{1'b0, 1'b0};
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (o_ok[i]) begin
          pend[i] = 0; rd[i] = 0; wr[i] = 0;
        end
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          a[i] = $urandom;
          d[i] = $urandom;
          w[i] = 2'($urandom_range(0, 2));
          case ($urandom_range(0, 7))
            0:       begin rd[i] = 1; wr[i] = 1; end
            1, 2, 3: begin rd[i] = 0; wr[i] = 1; end
            default: begin rd[i] = 1; wr[i] = 0; end
          endcase
        end
      end
      if (o_mrd | o_mwr) begin
        if (!prev) begin
          age = 0;
          lat = $urandom_range(0, TO + 2);
        end else begin
          age++;
        end
        prev = 1;
        mem_ok = (age == lat);
      end else begin
        prev = 0;
        mem_ok = ($urandom_range(0, 7) == 0);
      end
      mem_rdata = $urandom;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    int          hi, oks;
    logic [31:0] rdo;
    bit          ero;
    for (int i = 0; i < 2; i++) begin
      a[i] = '0; d[i] = '0; w[i] = 2'd2; rd[i] = 0; wr[i] = 0;
    end
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_busy", o_busy, 0);
    chk("rst_width", o_mwi, 2);

    run_tx(0, 32'h0800_0000, 32'h0, 2'd2, 1, 0, 3,
           32'hE3A0_0013, hi, oks, rdo, ero);
    chk("rd_strobe_cycles", hi, 4);
    chk("rd_ok_count", oks, 1);
    chk("rd_data", rdo, 32'hE3A0_0013);
    chk("rd_err", ero, 0);

    run_tx(1, 32'h0300_0001, 32'h0000_00AB, 2'd0, 0, 1, 2,
           32'hDEAD_BEEF, hi, oks, rdo, ero);
    chk("wr_strobe_cycles", hi, 3);
    chk("wr_ok_count", oks, 1);
    chk("wr_rdata", rdo, 0);

    run_tx(0, 32'h0200_0000, 32'h0, 2'd2, 1, 0, 100,
           32'h5555_5555, hi, oks, rdo, ero);
    chk("to_strobe_cycles", hi, 8);
    chk("to_ok_count", oks, 1);
    chk("to_err", ero, 1);
    chk("to_rdata", rdo, 0);

    run_tx(1, 32'h0200_0004, 32'h0, 2'd1, 1, 0, 0,
           32'h1234_5678, hi, oks, rdo, ero);
    chk("after_to_ok", oks, 1);
    chk("after_to_err", ero, 0);
    chk("after_to_rdata", rdo, 32'h1234_5678);

    a[0] = 32'h0800_0100; w[0] = 2'd2; rd[0] = 1; mem_ok = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    rd[0] = 0;
    chk("rib_read", o_mrd, 0);
    chk("rib_busy", o_busy, 0);
    chk("rib_width", o_mwi, 2);
    mem_ok = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rib_no_ok", o_ok[0], 0);
    end
    mem_ok = 0;

    do_reset();
    both_held(4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), gseq[i], i % 2);
    chk("rr_gap", gap_v, 2);

    sel = 1;
    do_reset();
    both_held(6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fp_grant%0d", i), gseq[i], 0);
    chk("fp_gap", gap_v, 2);

    do_reset();
    run_random(3000);
    sel = 0;
    do_reset();
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
